serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial WIDTH-bit subtractor computing d = a − b − bin, one bit per clock, LSB first, through a single full-subtractor cell and a borrow flop. It is the subtract-direction counterpart of the team's ripple-carry adder. It trades the combinational borrow chain for WIDTH cycles of latency. A start/busy/done handshake lets a controller issue one operation at a time.

## Interface
- WIDTH, default 4: operand and result width in bits; must be ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy = 0.
- a  input  WIDTH  minuend; sampled with start.
- b  input  WIDTH  subtrahend; sampled with start.
- bin  input  1  borrow-in; sampled with start.
- d  output  WIDTH  difference; registered, held until the next result.
- bout  output  1  borrow-out of the MSB stage; registered, held.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse when d and bout become valid.
- ovf  output  1  signed overflow; present only with SUB_OVF_EN.

## Operation
- States: IDLE, RUN.
- IDLE with start = 1:
  - latch a and b into shift registers; borrow flop ← bin; bit counter ← 0.
  - go to RUN; busy = 1.
- Each RUN cycle processes bit i = counter:
  - di = ai ^ bi ^ br
  - br_next = (~ai & bi) | (~(ai ^ bi) & br)
  - shift di into the result shift register; increment the counter.
- At the RUN cycle where counter = WIDTH−1, on that edge:
  - d ← the full result; bout ← br_next.
  - done ← 1 for one cycle; busy ← 0; state ← IDLE.
- start while busy = 1 is ignored. No queueing, no error flag. Operand changes during RUN have no effect.
- start in the same cycle that done is high is accepted, because busy is already 0. Back-to-back operations therefore issue every WIDTH+1 cycles.
- Arithmetic is modulo 2^WIDTH. bout = 1 iff a < b + bin as unsigned values.
- d and bout change only on a done edge or on reset.

## Timing
- Reset values: d = 0, bout = 0, busy = 0, done = 0, ovf = 0, state IDLE, counter 0, borrow flop 0.
- Reset is asynchronous. Asserting rst_n mid-RUN aborts the operation immediately: no done pulse, and outputs return to their reset values.
- Edge 0 samples start. busy is high from edge 0 through edge WIDTH.
- done is high for exactly one cycle, following edge WIDTH. Latency from start sample to valid result is WIDTH clocks.
- All outputs are driven directly from flops; there is no combinational input-to-output path.

## Configuration
- SUB_OVF_EN defined:
  - the ovf port exists.
  - ovf is registered on the done edge as (a[MSB] ≠ b[MSB]) & (d[MSB] ≠ a[MSB]), using the latched MSBs of a and b. Operands are treated as two's complement.
  - ovf holds until the next done edge or reset.
- SUB_OVF_EN undefined: no ovf port and no MSB-capture flops. All other behaviour is identical.

## Structure
- Package serial_sub_pkg holds:
  - the state enum typedef (IDLE, RUN).
  - the default WIDTH constant.
  - the counter width constant, $clog2(WIDTH).
- Sub-module full_sub_cell: combinational one-bit full subtractor (ai, bi, br → di, br_next), instantiated once.
- The top level holds the FSM, counter, shift registers and borrow flop.

## Test plan
- a=9, b=2, bin=0, start pulse → done exactly 4 cycles later; d=7, bout=0; busy high for 4 cycles.
- a=2, b=9, bin=0 → d=9, bout=1. Also a=0, b=0, bin=1 → d=15, bout=1.
- a=15, b=15, bin=1 → d=15, bout=1. Then a=10, b=5, bin=0 started in the done cycle → accepted; d=5, bout=0 after 4 more cycles.
- Start a=7, b=1; pulse start with a=1, b=1 two cycles later while busy → ignored; result d=6.
- Start a=9, b=2; drop rst_n after 2 cycles → busy=0, d=0, no done pulse. After release, a=9, b=2 completes normally with d=7.
- With SUB_OVF_EN: a=8, b=1, bin=0 → d=7, ovf=1. Then a=3, b=1 → d=2, ovf=0.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and constants for the bit-serial subtractor
package serial_sub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sub_state_t;

  localparam int SUB_WIDTH = 4;

  function automatic int sub_cnt_w(input int w);
    return $clog2(w);
  endfunction

  localparam int SUB_CNT_W = sub_cnt_w(SUB_WIDTH);

endpackage

// File: rtl/full_sub_cell.sv
// rtl/full_sub_cell.sv - combinational one-bit full subtractor
module full_sub_cell (
  input  logic i_ai,
  input  logic i_bi,
  input  logic i_br,
  output logic o_di,
  output logic o_br_next
);

  assign o_di      = i_ai ^ i_bi ^ i_br;
  assign o_br_next = (~i_ai & i_bi) | (~(i_ai ^ i_bi) & i_br);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin, LSB first, one bit per clock
// Optional signed overflow output enabled by SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
  output logic [WIDTH-1:0] o_d,
  output logic             o_bout,
  output logic             o_busy,
  output logic             o_done
`ifdef SUB_OVF_EN
  ,
  output logic             o_ovf
`endif
);

  localparam int CW = sub_cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sub_state_t       r_state;
  sub_state_t       w_state_next;
  logic             w_load;
  logic             w_last;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  logic             r_busy;
  logic             r_done;
  logic             w_di;
  logic             w_br_next;
  logic [WIDTH-1:0] w_res_next;

  full_sub_cell u_cell (
    .i_ai      (r_a[0]),
    .i_bi      (r_b[0]),
    .i_br      (r_br),
    .o_di      (w_di),
    .o_br_next (w_br_next)
  );

  // New bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
  assign w_res_next = {w_di, r_res};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_next = RUN;
          w_load       = 1'b1;
        end
      end
      RUN: begin
        if (r_cnt == LAST_BIT) begin
          w_state_next = IDLE;
          w_last       = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_cnt  <= '0;
      r_br   <= 1'b0;
      r_d    <= '0;
      r_bout <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_load) begin
        r_a    <= i_a;
        r_b    <= i_b;
        r_br   <= i_bin;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_state == RUN) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_br  <= w_br_next;
        r_res <= w_res_next[WIDTH-1:1];
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        if (w_last) begin
          r_d    <= w_res_next;
          r_bout <= w_br_next;
          r_busy <= 1'b0;
        end
      end
    end
  end

`ifdef SUB_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  // The final di is the result MSB, so overflow resolves on the same edge as d.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_load) begin
        r_a_msb <= i_a[WIDTH-1];
        r_b_msb <= i_b[WIDTH-1];
      end
      if (w_last) r_ovf <= (r_a_msb ^ r_b_msb) & (w_di ^ r_a_msb);
    end
  end

  assign o_ovf = r_ovf;
`endif

  assign o_d    = r_d;
  assign o_bout = r_bout;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor (SUB_OVF_EN aware)
module tb_serial_subtractor;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_start;
  logic [3:0] i_a;
  logic [3:0] i_b;
  logic       i_bin;
  logic [3:0] o_d;
  logic       o_bout;
  logic       o_busy;
  logic       o_done;
`ifdef SUB_OVF_EN
  logic       o_ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  serial_subtractor #(.WIDTH(4)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (i_start),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_bin   (i_bin),
    .o_d     (o_d),
    .o_bout  (o_bout),
    .o_busy  (o_busy),
    .o_done  (o_done)
`ifdef SUB_OVF_EN
    ,
    .o_ovf   (o_ovf)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
  task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic bin, input logic [3:0] exp_d, input logic exp_bout,
                       input logic exp_ovf);
    int lat;
    int bcnt;
    lat  = 0;
    bcnt = 0;
    i_a     = a;
    i_b     = b;
    i_bin   = bin;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    if (o_busy) bcnt++;
    while (!o_done && lat < 20) begin
      @(negedge i_clk);
      lat++;
      if (o_busy && !o_done) bcnt++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'd4);
    check({tag, "_d"}, 32'(o_d), 32'(exp_d));
    check({tag, "_bout"}, 32'(o_bout), 32'(exp_bout));
`ifdef SUB_OVF_EN
    check({tag, "_ovf"}, 32'(o_ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("unexpected ovf expectation in %s", tag);
`endif
  endtask

  initial begin
    int lat;
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_a     = '0;
    i_b     = '0;
    i_bin   = 1'b0;
    repeat (2) @(negedge i_clk);
    check("rst_d", 32'(o_d), 32'd0);
    check("rst_bout", 32'(o_bout), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
`ifdef SUB_OVF_EN
    check("rst_ovf", 32'(o_ovf), 32'd0);
`endif
    i_rst_n = 1'b1;
    @(negedge i_clk);

    do_op("op_9_2", 4'd9, 4'd2, 1'b0, 4'd7, 1'b0, 1'b1);
    @(negedge i_clk);
    check("op_9_2_done_single", 32'(o_done), 32'd0);
    check("op_9_2_d_held", 32'(o_d), 32'd7);

    do_op("op_2_9", 4'd2, 4'd9, 1'b0, 4'd9, 1'b1, 1'b1);
    @(negedge i_clk);
    do_op("op_0_0_b1", 4'd0, 4'd0, 1'b1, 4'd15, 1'b1, 1'b0);
    @(negedge i_clk);

    // Second op starts in the cycle done is high.
    do_op("op_15_15_b1", 4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0);
    do_op("op_b2b_10_5", 4'd10, 4'd5, 1'b0, 4'd5, 1'b0, 1'b1);
    @(negedge i_clk);

    // Start while busy must be ignored.
    i_a = 4'd7; i_b = 4'd1; i_bin = 1'b0; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    @(negedge i_clk);
    i_a = 4'd1; i_b = 4'd1; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    lat = 2;
    while (!o_done && lat < 20) begin
      @(negedge i_clk);
      lat++;
    end
    check("ign_latency", 32'(lat), 32'd4);
    check("ign_d", 32'(o_d), 32'd6);
    check("ign_bout", 32'(o_bout), 32'd0);
    @(negedge i_clk);

    // Asynchronous reset mid-run.
    i_a = 4'd9; i_b = 4'd2; i_bin = 1'b0; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    @(negedge i_clk);
    check("pre_rst_busy", 32'(o_busy), 32'd1);
    i_rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(o_busy), 32'd0);
    check("async_rst_d", 32'(o_d), 32'd0);
    check("async_rst_bout", 32'(o_bout), 32'd0);
    lat = 0;
    repeat (3) begin
      @(negedge i_clk);
      if (o_done) lat++;
    end
    i_rst_n = 1'b1;
    repeat (5) begin
      @(negedge i_clk);
      if (o_done || o_busy) lat++;
    end
    check("rst_abort_no_done", 32'(lat), 32'd0);
    do_op("post_rst_9_2", 4'd9, 4'd2, 1'b0, 4'd7, 1'b0, 1'b1);
    @(negedge i_clk);

`ifdef SUB_OVF_EN
    do_op("ovf_8_1", 4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 1'b1);
    @(negedge i_clk);
    check("ovf_held", 32'(o_ovf), 32'd1);
    do_op("ovf_3_1", 4'd3, 4'd1, 1'b0, 4'd2, 1'b0, 1'b0);
    @(negedge i_clk);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
